axi_lite_reg_bridge: RTL and testbench
======================================

# axi_lite_reg_bridge

AXI-Lite slave endpoint that terminates one slave port of the 1x4 AXI-Lite interconnect and converts each transaction into a single access on a simple request/acknowledge register bus for one peripheral (UART, GPIO, timer). It buffers AW, W and AR independently and arbitrates reads against writes round-robin. It returns B and R to the interconnect, with optional timeout recovery for peripherals that never acknowledge.

## Interface
Parameters:
- ADDR_W, 10, register-bus word-address width; reg_addr = captured AXI addr[ADDR_W+1:2] (4 KiB window at default).
- TIMEOUT_CYCLES, 256, cycles without reg_ack before a forced completion (used only with the macro); range 2..65535.

Ports (AXI-Lite side carries no BRESP/RRESP, matching the interconnect):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- s_awvalid / s_awready  in / out  1  write address handshake.
- s_awaddr  in  32  write address.
- s_awprot  in  3  accepted and ignored.
- s_wvalid / s_wready  in / out  1  write data handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte strobes.
- s_bvalid / s_bready  out / in  1  write response.
- s_arvalid / s_arready  in / out  1  read address handshake.
- s_araddr  in  32  read address.
- s_arprot  in  3  accepted and ignored.
- s_rvalid / s_rready  out / in  1  read response.
- s_rdata  out  32  read data.
- reg_req  out  1  access request; held until acknowledged.
- reg_we  out  1  1 = write, 0 = read; valid while reg_req.
- reg_addr  out  ADDR_W  word address.
- reg_wdata  out  32  write data.
- reg_wstrb  out  4  byte enables; 4'h0 on reads.
- reg_rdata  in  32  read data; sampled when reg_ack is high on a read.
- reg_ack  in  1  single-cycle completion; meaningful only while reg_req is high.
- err_pulse  out  1  one-cycle pulse on a timeout completion.

## Operation
- Holding registers:
  - aw_full captures awaddr.
  - w_full captures wdata and wstrb.
  - ar_full captures araddr.
  - Ready signals: s_awready = !aw_full, s_wready = !w_full, s_arready = !ar_full. All three are forced 0 while reset is high.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WR_BUS, RD_BUS, WR_RESP, RD_RESP.
- IDLE:
  - A write is pending when aw_full && w_full. A read is pending when ar_full.
  - Only one pending: go to WR_BUS or RD_BUS.
  - Both pending: grant the opposite of last_grant, then update last_grant. last_grant resets to READ, so the first contention goes to the write.
- WR_BUS / RD_BUS: reg_req = 1, with reg_we, reg_addr, reg_wdata, reg_wstrb taken from the holding registers.
  - On reg_ack, go to WR_RESP or RD_RESP.
  - On a read ack, load s_rdata from reg_rdata.
- WR_RESP: s_bvalid = 1. On s_bready, clear aw_full and w_full and return to IDLE.
- RD_RESP: s_rvalid = 1. On s_rready, clear ar_full and return to IDLE.
- A new AW/W/AR may be captured in any state if its holding register is empty. There is at most one outstanding transaction per channel.
- Reset (any state, mid-access included):
  - State goes to IDLE. All full flags cleared. last_grant = READ.
  - Outputs: reg_req 0, reg_we 0, reg_addr 0, reg_wdata 0, reg_wstrb 0, s_bvalid 0, s_rvalid 0, s_rdata 0, err_pulse 0, all readies 0.
  - An in-flight peripheral access is abandoned; a late reg_ack is ignored.

## Timing
- reg_req, reg_we, reg_addr, reg_wdata, reg_wstrb, s_bvalid, s_rvalid, s_rdata and err_pulse are registered.
- Readies are combinational from the full flags only.
- Write, AW and W in cycle 0: reg_req high in cycle 1. With reg_ack in cycle 1, s_bvalid is high in cycle 2. Best case is 2 cycles to B.
- Read, AR in cycle 0: reg_req high in cycle 1. With reg_ack in cycle 1, s_rvalid and s_rdata are valid in cycle 2.
- Each additional ack wait cycle adds one cycle of latency.
- The B/R response is held stable until its ready is sampled high.
- Back-to-back: the same-channel holding register frees in the response handshake cycle. The next access therefore reaches reg_req no earlier than 2 cycles after that handshake.
- reg_ack while reg_req is low is ignored.

## Configuration
- REGBRIDGE_TIMEOUT_EN defined:
  - A counter runs in WR_BUS / RD_BUS and clears on entry.
  - If TIMEOUT_CYCLES cycles elapse with no reg_ack, the bridge drops reg_req and goes to WR_RESP or RD_RESP.
  - A timed-out read returns s_rdata = 32'hDEAD_BEEF.
  - err_pulse is high for one cycle, coinciding with the first s_bvalid / s_rvalid cycle.
  - An ack in the same cycle as expiry wins: normal completion, no err_pulse.
- Not defined: no counter; the bridge waits for reg_ack indefinitely; err_pulse is tied 0.

## Test plan
- Write: AW addr 0x0000_0010 and W 0xCAFE_0001 / strb 4'hF in cycle 0; ack in cycle 1 -> reg_addr 10'h004, reg_we 1; s_bvalid in cycle 2.
- W before AW: W in cycle 0, AW in cycle 3 -> no reg_req before cycle 4; s_wready low in cycles 1-3.
- Read: AR 0x0000_0008 with peripheral acking 3 cycles late and reg_rdata 0x1234_5678 -> s_rvalid with 0x1234_5678 in the cycle after the ack; held while s_rready is low.
- Contention: write and read both pending in IDLE from reset -> write goes first. Repeating the scenario -> read goes first.
- Timeout (macro on, TIMEOUT_CYCLES 8): read, never acked -> reg_req drops after 8 cycles; s_rdata 0xDEAD_BEEF; err_pulse for one cycle. The same scenario with the macro off keeps reg_req high for 1000 cycles.
- Reset asserted in RD_BUS -> next cycle reg_req 0, all readies 0. After release: s_arready 1, and a late reg_ack produces no s_rvalid.

Source files
------------

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI-Lite bundle (no BRESP/RRESP) between the interconnect slave port
// and the register bridge.
interface axi_lite_reg_bridge_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid;
    logic        s_bready;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;

    modport master (
        output s_awvalid, s_awaddr, s_awprot,
        output s_wvalid, s_wdata, s_wstrb,
        output s_bready,
        output s_arvalid, s_araddr, s_arprot,
        output s_rready,
        input  s_awready, s_wready, s_bvalid,
        input  s_arready, s_rvalid, s_rdata
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_awprot,
        input  s_wvalid, s_wdata, s_wstrb,
        input  s_bready,
        input  s_arvalid, s_araddr, s_arprot,
        input  s_rready,
        output s_awready, s_wready, s_bvalid,
        output s_arready, s_rvalid, s_rdata
    );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave to req/ack register bus bridge, round-robin read/write.
// Define REGBRIDGE_TIMEOUT_EN for ack-timeout recovery (err_pulse).
module axi_lite_reg_bridge #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    axi_lite_reg_bridge_if.slave s,
    output logic                 reg_req,
    output logic                 reg_we,
    output logic [ADDR_W-1:0]    reg_addr,
    output logic [31:0]          reg_wdata,
    output logic [3:0]           reg_wstrb,
    input  logic [31:0]          reg_rdata,
    input  logic                 reg_ack,
    output logic                 err_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BUS,
        RD_BUS,
        WR_RESP,
        RD_RESP
    } state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    state_e state_q, state_d;
    logic   last_rd_q, last_rd_d;

    logic        aw_full_q, aw_full_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        w_full_q, w_full_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ar_full_q, ar_full_d;
    logic [31:0] araddr_q, araddr_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       bwdata_q, bwdata_d;
    logic [3:0]        bwstrb_q, bwstrb_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_pend, rd_pend;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strb;
    logic        expired;

    assign s.s_awready = !aw_full_q && !reset;
    assign s.s_wready  = !w_full_q && !reset;
    assign s.s_arready = !ar_full_q && !reset;

    assign aw_hs = s.s_awvalid && s.s_awready;
    assign w_hs  = s.s_wvalid && s.s_wready;
    assign ar_hs = s.s_arvalid && s.s_arready;

    // IDLE may launch on a beat arriving this very cycle, hence the bypass.
    assign wr_addr = aw_full_q ? awaddr_q : s.s_awaddr;
    assign wr_data = w_full_q ? wdata_q : s.s_wdata;
    assign wr_strb = w_full_q ? wstrb_q : s.s_wstrb;
    assign rd_addr = ar_full_q ? araddr_q : s.s_araddr;

    assign wr_pend = (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign rd_pend = ar_full_q || ar_hs;

`ifdef REGBRIDGE_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == WR_BUS || state_q == RD_BUS) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TO_LAST);
`else
    logic unused_to;
    assign unused_to = ^TO_LAST;
    assign expired   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ar_full_d = ar_full_q;
        araddr_d  = araddr_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        bwdata_d  = bwdata_q;
        bwstrb_d  = bwstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            awaddr_d  = s.s_awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = s.s_wdata;
            wstrb_d  = s.s_wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            araddr_d  = s.s_araddr;
        end

        case (state_q)
            IDLE: begin
                if (wr_pend && (!rd_pend || last_rd_q)) begin
                    state_d  = WR_BUS;
                    req_d    = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = wr_addr[ADDR_W+1:2];
                    bwdata_d = wr_data;
                    bwstrb_d = wr_strb;
                    if (rd_pend) begin
                        last_rd_d = 1'b0;
                    end
                end else if (rd_pend) begin
                    state_d  = RD_BUS;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = rd_addr[ADDR_W+1:2];
                    bwdata_d = '0;
                    bwstrb_d = '0;
                    if (wr_pend) begin
                        last_rd_d = 1'b1;
                    end
                end
            end
            WR_BUS: begin
                if (reg_ack || expired) begin
                    state_d  = WR_RESP;
                    req_d    = 1'b0;
                    bvalid_d = 1'b1;
                    err_d    = !reg_ack;
                end
            end
            RD_BUS: begin
                if (reg_ack || expired) begin
                    state_d  = RD_RESP;
                    req_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rdata_d  = reg_ack ? reg_rdata : TO_DATA;
                    err_d    = !reg_ack;
                end
            end
            WR_RESP: begin
                if (s.s_bready) begin
                    state_d   = IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            RD_RESP: begin
                if (s.s_rready) begin
                    state_d   = IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            aw_full_q <= 1'b0;
            awaddr_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ar_full_q <= 1'b0;
            araddr_q  <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            bwdata_q  <= '0;
            bwstrb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            aw_full_q <= aw_full_d;
            awaddr_q  <= awaddr_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ar_full_q <= ar_full_d;
            araddr_q  <= araddr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            bwdata_q  <= bwdata_d;
            bwstrb_q  <= bwstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign reg_req   = req_q;
    assign reg_we    = we_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = bwdata_q;
    assign reg_wstrb = bwstrb_q;
    assign err_pulse = err_q;

    assign s.s_bvalid = bvalid_q;
    assign s.s_rvalid = rvalid_q;
    assign s.s_rdata  = rdata_q;

    // Protection bits and out-of-window address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s.s_awprot, s.s_arprot,
                           wr_addr[31:ADDR_W+2], wr_addr[1:0],
                           rd_addr[31:ADDR_W+2], rd_addr[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Bench for axi_lite_reg_bridge: transaction-queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_axi_lite_reg_bridge;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        reg_req;
    logic        reg_we;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        err_pulse;

    int total = 0;
    int bad   = 0;

    axi_lite_reg_bridge_if bus ();

    axi_lite_reg_bridge #(
        .ADDR_W         (10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (bus),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wstrb (reg_wstrb),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    logic [31:0] awq[$];
    logic [35:0] wq[$];
    logic [31:0] arq[$];
    bit          m_ok = 0;
    bit          m_busy, m_resp, m_last_rd, m_err;
    txn_t        m_cur;
    int          m_wait;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        bit idle, aw_acc, w_acc, ar_acc, want_wr, want_rd, pick_rd;
        if (reset) begin
            awq.delete();
            wq.delete();
            arq.delete();
            m_ok      = 1;
            m_busy    = 0;
            m_resp    = 0;
            m_last_rd = 1;
            m_err     = 0;
            m_wait    = 0;
            m_rdata   = '0;
        end else begin
            idle   = !m_busy;
            aw_acc = bus.s_awvalid && awq.size() == 0;
            w_acc  = bus.s_wvalid && wq.size() == 0;
            ar_acc = bus.s_arvalid && arq.size() == 0;
            m_err  = 0;
            if (m_busy && !m_resp) begin
                if (reg_ack) begin
                    m_resp = 1;
                    if (m_cur.rd) m_rdata = reg_rdata;
                end
`ifdef REGBRIDGE_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait >= TO) begin
                        m_resp = 1;
                        m_err  = 1;
                        if (m_cur.rd) m_rdata = 32'hDEAD_BEEF;
                    end
                end
`endif
            end else if (m_busy) begin
                if (m_cur.rd && bus.s_rready) begin
                    void'(arq.pop_front());
                    m_busy = 0;
                    m_resp = 0;
                end else if (!m_cur.rd && bus.s_bready) begin
                    void'(awq.pop_front());
                    void'(wq.pop_front());
                    m_busy = 0;
                    m_resp = 0;
                end
            end
            if (aw_acc) awq.push_back(bus.s_awaddr);
            if (w_acc) wq.push_back({bus.s_wstrb, bus.s_wdata});
            if (ar_acc) arq.push_back(bus.s_araddr);
            if (idle) begin
                want_wr = awq.size() > 0 && wq.size() > 0;
                want_rd = arq.size() > 0;
                if (want_wr && want_rd) begin
                    pick_rd   = !m_last_rd;
                    m_last_rd = pick_rd;
                end else begin
                    pick_rd = want_rd;
                end
                if (want_wr || want_rd) begin
                    m_busy = 1;
                    m_resp = 0;
                    m_wait = 0;
                    if (pick_rd) begin
                        m_cur.rd   = 1'b1;
                        m_cur.addr = arq[0];
                        m_cur.data = '0;
                        m_cur.strb = '0;
                    end else begin
                        m_cur.rd   = 1'b0;
                        m_cur.addr = awq[0];
                        m_cur.data = wq[0][31:0];
                        m_cur.strb = wq[0][35:32];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("awready", bus.s_awready, !reset && awq.size() == 0);
            chk("wready", bus.s_wready, !reset && wq.size() == 0);
            chk("arready", bus.s_arready, !reset && arq.size() == 0);
            chk("reg_req", reg_req, m_busy && !m_resp);
            chk("bvalid", bus.s_bvalid, m_busy && m_resp && !m_cur.rd);
            chk("rvalid", bus.s_rvalid, m_busy && m_resp && m_cur.rd);
            chk("err_pulse", err_pulse, m_err);
            if (m_busy && !m_resp) begin
                chk("reg_we", reg_we, !m_cur.rd);
                chk("reg_addr", reg_addr, m_cur.addr[11:2]);
                chk("reg_wstrb", reg_wstrb, m_cur.rd ? 4'h0 : m_cur.strb);
                if (!m_cur.rd) chk("reg_wdata", reg_wdata, m_cur.data);
            end
            if (m_busy && m_resp && m_cur.rd) begin
                chk("rdata", bus.s_rdata, m_rdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int maxc);
        int n = 0;
        while (!reg_req && n < maxc) begin
            tick();
            n++;
        end
        chk("req_wait", reg_req, 1);
    endtask

    task automatic set_aw(input logic [31:0] a);
        bus.s_awvalid = 1'b1;
        bus.s_awaddr  = a;
    endtask

    task automatic set_w(input logic [31:0] d, input logic [3:0] st);
        bus.s_wvalid = 1'b1;
        bus.s_wdata  = d;
        bus.s_wstrb  = st;
    endtask

    task automatic set_ar(input logic [31:0] a);
        bus.s_arvalid = 1'b1;
        bus.s_araddr  = a;
    endtask

    task automatic clr_valids();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.s_awvalid = 1'b0;
        bus.s_awaddr  = '0;
        bus.s_awprot  = 3'h2;
        bus.s_wvalid  = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_bready  = 1'b0;
        bus.s_arvalid = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arprot  = 3'h1;
        bus.s_rready  = 1'b0;
        reg_rdata     = '0;
        reg_ack       = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_req", reg_req, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_wstrb", reg_wstrb, 0);
        chk("rst_bvalid", bus.s_bvalid, 0);
        chk("rst_rvalid", bus.s_rvalid, 0);
        chk("rst_rdata", bus.s_rdata, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_rdy", {bus.s_awready, bus.s_wready, bus.s_arready}, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

        // write, AW and W together
        set_aw(32'h0000_0010);
        set_w(32'hCAFE_0001, 4'hF);
        tick();
        clr_valids();
        chk("wr_req", reg_req, 1);
        chk("wr_we", reg_we, 1);
        chk("wr_addr", reg_addr, 10'h004);
        chk("wr_wdata", reg_wdata, 32'hCAFE_0001);
        chk("wr_wstrb", reg_wstrb, 4'hF);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("wr_bvalid", bus.s_bvalid, 1);
        chk("wr_req_off", reg_req, 0);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        chk("wr_bdone", bus.s_bvalid, 0);

        // W before AW
        set_w(32'h55AA_0002, 4'h3);
        tick();
        clr_valids();
        for (int k = 1; k <= 3; k++) begin
            chk("wfirst_wready", bus.s_wready, 0);
            chk("wfirst_noreq", reg_req, 0);
            if (k == 3) set_aw(32'h0000_0024);
            tick();
        end
        clr_valids();
        chk("wfirst_req", reg_req, 1);
        chk("wfirst_addr", reg_addr, 10'h009);
        chk("wfirst_wstrb", reg_wstrb, 4'h3);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("wfirst_bvalid", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;

        // read with ack three cycles late, R held while rready low
        set_ar(32'h0000_0008);
        tick();
        clr_valids();
        chk("rd_req", reg_req, 1);
        chk("rd_we", reg_we, 0);
        chk("rd_addr", reg_addr, 10'h002);
        chk("rd_wstrb", reg_wstrb, 0);
        tick();
        tick();
        tick();
        chk("rd_req_wait", reg_req, 1);
        reg_ack   = 1'b1;
        reg_rdata = 32'h1234_5678;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = 32'h0BAD_0BAD;
        chk("rd_rvalid", bus.s_rvalid, 1);
        chk("rd_rdata", bus.s_rdata, 32'h1234_5678);
        tick();
        chk("rd_hold_valid", bus.s_rvalid, 1);
        chk("rd_hold_data", bus.s_rdata, 32'h1234_5678);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
        chk("rd_done", bus.s_rvalid, 0);

        // contention from reset: write first
        do_reset(2);
        set_aw(32'h0000_0030);
        set_w(32'h1111_2222, 4'hC);
        set_ar(32'h0000_0040);
        tick();
        clr_valids();
        chk("c1_req", reg_req, 1);
        chk("c1_we", reg_we, 1);
        chk("c1_addr", reg_addr, 10'h00C);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("c1_bvalid", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        wait_req(4);
        chk("c1_rd_we", reg_we, 0);
        chk("c1_rd_addr", reg_addr, 10'h010);
        reg_ack   = 1'b1;
        reg_rdata = 32'hA5A5_5A5A;
        tick();
        reg_ack = 1'b0;
        chk("c1_rdata", bus.s_rdata, 32'hA5A5_5A5A);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;

        // contention repeated: read first
        set_aw(32'h0000_0050);
        set_w(32'h3333_4444, 4'h1);
        set_ar(32'h0000_0060);
        tick();
        clr_valids();
        chk("c2_req", reg_req, 1);
        chk("c2_we", reg_we, 0);
        chk("c2_addr", reg_addr, 10'h018);
        reg_ack   = 1'b1;
        reg_rdata = 32'h0F0F_F0F0;
        tick();
        reg_ack = 1'b0;
        chk("c2_rvalid", bus.s_rvalid, 1);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
        wait_req(4);
        chk("c2_wr_we", reg_we, 1);
        chk("c2_wr_addr", reg_addr, 10'h014);
        chk("c2_wr_wdata", reg_wdata, 32'h3333_4444);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        chk("c2_bvalid", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;

        // peripheral that never acks
        set_ar(32'h0000_000C);
        tick();
        clr_valids();
`ifdef REGBRIDGE_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            chk("to_req", reg_req, 1);
            tick();
        end
        chk("to_req_drop", reg_req, 0);
        chk("to_rvalid", bus.s_rvalid, 1);
        chk("to_rdata", bus.s_rdata, 32'hDEAD_BEEF);
        chk("to_err", err_pulse, 1);
        tick();
        chk("to_err_once", err_pulse, 0);
        chk("to_rvalid_hold", bus.s_rvalid, 1);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
        set_ar(32'h0000_0014);
        tick();
        clr_valids();
        tick();
`else
        for (int k = 0; k < 1000; k++) begin
            chk("hold_req", reg_req, 1);
            tick();
        end
        chk("hold_err", err_pulse, 0);
`endif

        // reset while in RD_BUS, then a late ack
        chk("rb_req_before", reg_req, 1);
        reset = 1'b1;
        #1;
        chk("rb_rdy_comb", {bus.s_awready, bus.s_wready, bus.s_arready}, 0);
        tick();
        chk("rb_req", reg_req, 0);
        chk("rb_rdy", {bus.s_awready, bus.s_wready, bus.s_arready}, 0);
        reset   = 1'b0;
        reg_ack = 1'b1;
        #1;
        chk("rb_arready", bus.s_arready, 1);
        tick();
        reg_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rb_no_rvalid", bus.s_rvalid, 0);
            chk("rb_no_req", reg_req, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
